// File: rtl/score_display_mux_if.sv
// Score load channel: the score source (master) requests conversions,
// and score_display_mux (slave) reports busy and overflow status.
interface score_display_mux_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] score;
  logic             score_valid;
  logic             busy;
  logic             overflow;

  modport master (
    output score,
    output score_valid,
    input  busy,
    input  overflow
  );

  modport slave (
    input  score,
    input  score_valid,
    output busy,
    output overflow
  );
endinterface

// File: rtl/score_display_mux.sv
// Binary score to BCD (sequential shift-add-3), then time-multiplexed
// active-low seven-segment drive with leading-zero blanking and decimal points.
module score_display_mux #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                clk_100mhz,
  input  logic                rst,
  score_display_mux_if.slave  load,
  input  logic [DIGITS-1:0]   dp_mask,
  output logic [7:0]          segment,
  output logic [DIGITS-1:0]   AN
);

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [BIN_W-1:0]  bin_sr;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  bit_cnt;
  logic              ovf_pend;
  logic              pend_valid;
  logic [BIN_W-1:0]  pend_score;
  logic [BCD_W-1:0]  disp_bcd;
  logic              busy_r;
  logic              overflow_r;
  logic [BIN_W-1:0]  next_score;

  logic [DIV_W-1:0]  div_cnt;
  logic [K_W-1:0]    k;
  logic [3:0]        nib;
  logic              blank;
  logic [6:0]        glyph;

  function automatic logic is_over(input logic [BIN_W-1:0] v);
    return 32'(v) > MAX_VAL;
  endfunction

  function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] v);
    if (is_over(v)) return BIN_W'(MAX_VAL);
    return v;
  endfunction

  assign load.busy     = busy_r;
  assign load.overflow = overflow_r;

  // A request arriving exactly at DONE is as fresh as the pending one, so it wins.
  assign next_score = load.score_valid ? load.score : pend_score;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state      <= IDLE;
      bin_sr     <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      ovf_pend   <= 1'b0;
      pend_valid <= 1'b0;
      pend_score <= '0;
      disp_bcd   <= '0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load.score_valid) begin
            bin_sr   <= saturate(load.score);
            ovf_pend <= is_over(load.score);
            bcd      <= '0;
            bit_cnt  <= CNT_W'(BIN_W - 1);
            busy_r   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (load.score_valid) begin
            pend_valid <= 1'b1;
            pend_score <= load.score;
          end
          bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
          bin_sr <= bin_sr << 1;
          if (bit_cnt == '0) state <= DONE;
          else               bit_cnt <= bit_cnt - CNT_W'(1);
        end
        DONE: begin
          disp_bcd   <= bcd;
          overflow_r <= ovf_pend;
          if (load.score_valid || pend_valid) begin
            bin_sr     <= saturate(next_score);
            ovf_pend   <= is_over(next_score);
            bcd        <= '0;
            bit_cnt    <= CNT_W'(BIN_W - 1);
            pend_valid <= 1'b0;
            state      <= SHIFT;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A digit blanks when it and every more-significant digit are zero.
  always_comb begin
    nib   = disp_bcd[{k, 2'b00} +: 4];
    blank = BLANK_LZ && (k != '0) && ((disp_bcd >> {k, 2'b00}) == '0);
    glyph = 7'h7F;
    if (!blank) begin
      case (nib)
        4'd0:    glyph = 7'h40;
        4'd1:    glyph = 7'h79;
        4'd2:    glyph = 7'h24;
        4'd3:    glyph = 7'h30;
        4'd4:    glyph = 7'h19;
        4'd5:    glyph = 7'h12;
        4'd6:    glyph = 7'h02;
        4'd7:    glyph = 7'h78;
        4'd8:    glyph = 7'h00;
        4'd9:    glyph = 7'h10;
        default: glyph = 7'h7F;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      div_cnt <= '0;
      k       <= '0;
      AN      <= ~DIGITS'(1);
      segment <= {~dp_mask[0], 7'h40};
    end else begin
      if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt <= '0;
        k       <= (k == K_W'(DIGITS - 1)) ? '0 : k + K_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      AN      <= ~(DIGITS'(1) << k);
      segment <= {~dp_mask[k], glyph};
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Randomized and directed bench for score_display_mux, checked every cycle
// against an arithmetic model of the committed score and scan position.
module tb_score_display_mux;
  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;
  localparam int unsigned MAX_VAL = 9999;

  logic              clk_100mhz = 1'b0;
  logic              rst = 1'b1;
  logic [BIN_W-1:0]  score = '0;
  logic              score_valid = 1'b0;
  logic [DIGITS-1:0] dp_mask = '0;
  logic [7:0]        segment, segment_nb;
  logic [DIGITS-1:0] an, an_nb;

  int n_cmp = 0;
  int n_bad = 0;

  score_display_mux_if #(.BIN_W(BIN_W)) lz_if ();
  score_display_mux_if #(.BIN_W(BIN_W)) nb_if ();

  assign lz_if.score       = score;
  assign lz_if.score_valid = score_valid;
  assign nb_if.score       = score;
  assign nb_if.score_valid = score_valid;

  always #5 clk_100mhz = ~clk_100mhz;

  score_display_mux #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)
  ) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .load(lz_if),
    .dp_mask(dp_mask), .segment(segment), .AN(an)
  );

  score_display_mux #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)
  ) dut_nb (
    .clk_100mhz(clk_100mhz), .rst(rst), .load(nb_if),
    .dp_mask(dp_mask), .segment(segment_nb), .AN(an_nb)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int unsigned v, input int d, input bit blank_lz);
    int unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (blank_lz && d > 0 && v < p) return 7'h7F;
    case ((v / p) % 10)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // Model: a load commits BIN_W+1 edges later; display lags the scan index by one edge.
  bit                m_started = 0;
  bit                m_active, m_pend, m_job_ovf, m_ovf;
  int unsigned       m_disp, m_job_val, m_pend_val;
  longint            m_cycle, m_commit_at;
  int                m_scan, m_d;
  logic [DIGITS-1:0] exp_an;
  logic [7:0]        exp_seg_lz, exp_seg_nb;

  task automatic model_start(input int unsigned v);
    m_active    = 1;
    m_commit_at = m_cycle + BIN_W + 1;
    m_job_ovf   = (v > MAX_VAL);
    m_job_val   = (v > MAX_VAL) ? MAX_VAL : v;
  endtask

  always @(posedge clk_100mhz) begin
    if (rst) begin
      m_started  = 1;
      m_active   = 0;
      m_pend     = 0;
      m_ovf      = 0;
      m_disp     = 0;
      m_cycle    = 0;
      m_scan     = 0;
      exp_an     = ~DIGITS'(1);
      exp_seg_lz = {~dp_mask[0], glyph(0, 0, 1'b1)};
      exp_seg_nb = {~dp_mask[0], glyph(0, 0, 1'b0)};
    end else if (m_started) begin
      m_cycle++;
      m_d        = (m_scan / SCAN_DIV) % DIGITS;
      exp_an     = ~(DIGITS'(1) << m_d);
      exp_seg_lz = {~dp_mask[m_d], glyph(m_disp, m_d, 1'b1)};
      exp_seg_nb = {~dp_mask[m_d], glyph(m_disp, m_d, 1'b0)};
      m_scan++;
      if (m_active && m_cycle == m_commit_at) begin
        m_disp = m_job_val;
        m_ovf  = m_job_ovf;
        if (score_valid) model_start(score);
        else if (m_pend) model_start(m_pend_val);
        else m_active = 0;
        m_pend = 0;
      end else if (m_active) begin
        if (score_valid) begin
          m_pend     = 1;
          m_pend_val = score;
        end
      end else if (score_valid) begin
        model_start(score);
      end
    end
  end

  always @(negedge clk_100mhz) begin
    if (m_started) begin
      checkOutput("an", 32'(an), 32'(exp_an));
      checkOutput("an_nb", 32'(an_nb), 32'(exp_an));
      checkOutput("segment", 32'(segment), 32'(exp_seg_lz));
      checkOutput("segment_nb", 32'(segment_nb), 32'(exp_seg_nb));
      checkOutput("busy", 32'(lz_if.busy), 32'(m_active));
      checkOutput("overflow", 32'(lz_if.overflow), 32'(m_ovf));
    end
  end

  task automatic applyStimulus(input logic [BIN_W-1:0] s);
    score       = s;
    score_valid = 1'b1;
    @(negedge clk_100mhz);
    score_valid = 1'b0;
  endtask

  task automatic wait_digit(input int d);
    bit found;
    found = 0;
    for (int i = 0; i < 2 * DIGITS * SCAN_DIV && !found; i++) begin
      @(negedge clk_100mhz);
      if (an == ~(DIGITS'(1) << d)) found = 1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL wait_digit%0d: AN stuck at %b, required digit %0d enabled", d, an, d);
    end
  endtask

  task automatic wait_idle();
    bit found;
    found = 0;
    for (int i = 0; i < 4 * (BIN_W + 1) && !found; i++) begin
      @(negedge clk_100mhz);
      if (!lz_if.busy) found = 1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL wait_idle: busy still %b, required 0", lz_if.busy);
    end
  endtask

  task automatic check_digit(input string name, input int d, input logic [7:0] lz, input logic [7:0] nb);
    wait_digit(d);
    checkOutput({name, "_lz"}, 32'(segment), 32'(lz));
    checkOutput({name, "_nb"}, 32'(segment_nb), 32'(nb));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk_100mhz);
    rst = 1'b0;
    $display("[TB] reset and idle scan");
    checkOutput("rst_an", 32'(an), 32'h0000_000E);
    checkOutput("rst_seg", 32'(segment), 32'h0000_00C0);
    checkOutput("rst_busy", 32'(lz_if.busy), 32'h0);
    check_digit("idle_d1", 1, 8'hFF, 8'hC0);
    checkOutput("idle_an1", 32'(an), 32'h0000_000D);
    check_digit("idle_d2", 2, 8'hFF, 8'hC0);
    check_digit("idle_d3", 3, 8'hFF, 8'hC0);
    checkOutput("idle_an3", 32'(an), 32'h0000_0007);

    $display("[TB] load 1234");
    @(negedge clk_100mhz);
    applyStimulus(14'd1234);
    checkOutput("lat_busy_t1", 32'(lz_if.busy), 32'h1);
    repeat (BIN_W) @(negedge clk_100mhz);
    checkOutput("lat_busy_t15", 32'(lz_if.busy), 32'h1);
    @(negedge clk_100mhz);
    checkOutput("lat_busy_t16", 32'(lz_if.busy), 32'h0);
    checkOutput("ovf_1234", 32'(lz_if.overflow), 32'h0);
    check_digit("d3_1234", 3, 8'hF9, 8'hF9);
    check_digit("d2_1234", 2, 8'hA4, 8'hA4);
    check_digit("d1_1234", 1, 8'hB0, 8'hB0);
    check_digit("d0_1234", 0, 8'h99, 8'h99);

    $display("[TB] load 7 with dp on digit 1");
    dp_mask = 4'b0010;
    applyStimulus(14'd7);
    wait_idle();
    check_digit("d0_7", 0, 8'hF8, 8'hF8);
    check_digit("d1_7", 1, 8'h7F, 8'h40);
    check_digit("d2_7", 2, 8'hFF, 8'hC0);
    check_digit("d3_7", 3, 8'hFF, 8'hC0);

    $display("[TB] saturation");
    dp_mask = 4'b0000;
    applyStimulus(14'd12000);
    wait_idle();
    checkOutput("ovf_12000", 32'(lz_if.overflow), 32'h1);
    check_digit("d3_sat", 3, 8'h90, 8'h90);
    check_digit("d0_sat", 0, 8'h90, 8'h90);
    applyStimulus(14'd0);
    wait_idle();
    checkOutput("ovf_clear", 32'(lz_if.overflow), 32'h0);
    check_digit("d0_zero", 0, 8'hC0, 8'hC0);
    check_digit("d1_zero", 1, 8'hFF, 8'hC0);

    $display("[TB] back-to-back loads");
    applyStimulus(14'd100);
    repeat (2) @(negedge clk_100mhz);
    applyStimulus(14'd200);
    @(negedge clk_100mhz);
    applyStimulus(14'd300);
    repeat (10) @(negedge clk_100mhz);
    checkOutput("b2b_busy_t16", 32'(lz_if.busy), 32'h1);
    n = 0;
    while (lz_if.busy && n < 4 * BIN_W) begin
      @(negedge clk_100mhz);
      n++;
    end
    checkOutput("b2b_latency", 32'(n), 32'd15);
    check_digit("d2_300", 2, 8'hB0, 8'hB0);
    check_digit("d1_300", 1, 8'hC0, 8'hC0);

    $display("[TB] reset during conversion");
    applyStimulus(14'd5555);
    repeat (7) @(negedge clk_100mhz);
    rst = 1'b1;
    @(negedge clk_100mhz);
    rst = 1'b0;
    checkOutput("mid_rst_busy", 32'(lz_if.busy), 32'h0);
    checkOutput("mid_rst_an", 32'(an), 32'h0000_000E);
    checkOutput("mid_rst_seg", 32'(segment), 32'h0000_00C0);
    applyStimulus(14'd42);
    wait_idle();
    check_digit("d1_42", 1, 8'h99, 8'h99);
    check_digit("d0_42", 0, 8'hA4, 8'hA4);
    check_digit("d2_42", 2, 8'hFF, 8'hC0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      score       = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      score_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) dp_mask = DIGITS'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk_100mhz);
    end
    score_valid = 1'b0;
    rst = 1'b0;
    wait_idle();
    repeat (DIGITS * SCAN_DIV) @(negedge clk_100mhz);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
